dsp_imem_loader: RTL

//  Program memory and loader for the DSP core: the responder to the core sequencer's fetch port.

---
 rtl/dsp_imem_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dsp_imem_loader.sv
// Program memory and loader for the DSP core: host streams a program in, the block
// starts the sequencer, serves its fetches and detects run completion.
module dsp_imem_loader #(
    parameter int unsigned           ADDR_W  = 8,
    parameter int unsigned           DATA_W  = 16,
    parameter logic [DATA_W-1:0]     HALT_OP = 16'hF000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [15:0]       pc,
    output logic [DATA_W-1:0] instr,
    input  logic              core_done,
    output logic              core_start,
    output logic              run_done,
    output logic              busy,
    output logic [ADDR_W:0]   prog_len,
    output logic              err_overflow,
    output logic              err_fetch_oob
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ARM  = 2'd2;
    localparam logic [1:0] RUN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              err_overflow_q, err_overflow_d;
    logic              err_fetch_oob_q, err_fetch_oob_d;
    logic              done_q, done_d;
    logic              run_done_q, run_done_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              mem_we;
    logic              pc_in_range;

    logic [DATA_W-1:0] mem [DEPTH];

    // Compare at 32 bits so any pc upper bits above ADDR_W count as out of range.
    assign pc_in_range = 32'(pc) < 32'(prog_len_q);

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        prog_len_d      = prog_len_q;
        err_overflow_d  = err_overflow_q;
        err_fetch_oob_d = err_fetch_oob_q;
        done_d          = done_q;
        run_done_d      = 1'b0;
        instr_d         = '0;
        mem_we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d         = LOAD;
                    wr_ptr_d        = '0;
                    prog_len_d      = '0;
                    err_overflow_d  = 1'b0;
                    err_fetch_oob_d = 1'b0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    wr_ptr_d = '0;
                end else if (ld_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (ld_last) begin
                        state_d    = ARM;
                        prog_len_d = {1'b0, wr_ptr_q} + 1'b1;
                    end else if (&wr_ptr_q) begin
                        state_d        = IDLE;
                        err_overflow_d = 1'b1;
                        prog_len_d     = '0;
                    end
                end
            end
            ARM: begin
                done_d  = core_done;
                state_d = RUN;
            end
            RUN: begin
                done_d = core_done;
                if (pc_in_range) begin
                    instr_d = mem[pc[ADDR_W-1:0]];
                end else begin
                    instr_d         = HALT_OP;
                    err_fetch_oob_d = 1'b1;
                end
                // A level already high when RUN was entered was latched in ARM, so only a new rise ends the run.
                if (core_done && !done_q) begin
                    run_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            prog_len_q      <= '0;
            err_overflow_q  <= 1'b0;
            err_fetch_oob_q <= 1'b0;
            done_q          <= 1'b0;
            run_done_q      <= 1'b0;
            instr_q         <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            prog_len_q      <= prog_len_d;
            err_overflow_q  <= err_overflow_d;
            err_fetch_oob_q <= err_fetch_oob_d;
            done_q          <= done_d;
            run_done_q      <= run_done_d;
            instr_q         <= instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= ld_data;
        end
    end

    assign ld_ready      = (state_q == LOAD);
    assign core_start    = (state_q == ARM);
    assign busy          = (state_q != IDLE);
    assign run_done      = run_done_q;
    assign instr         = instr_q;
    assign prog_len      = prog_len_q;
    assign err_overflow  = err_overflow_q;
    assign err_fetch_oob = err_fetch_oob_q;

endmodule
